// File: rtl/control_unit.sv
// control_unit: multi-cycle fetch/execute sequencer for the tiny16 core.
// Owns the instruction register and drives the register-file selects and
// write strobes, the PC/SP update strobes and the single-port memory
// request handshake. One instruction is in flight at a time.
//
// state | meaning
// ------+--------------------------------------------------------------
// FETCH | read mem[PC]; on mem_ready latch ir and increment PC
// EXEC  | decode ir, drive strobes; LD/ST/POP hold request until ready
// MEM   | second step of PUSH (store) and POP (SP increment)
// HALT  | HLT executed; all strobes idle until rst
//
// Ports:
//   clk, rst              clock, async active-high reset
//   mem_rdata, mem_ready  memory read data / request completion
//   flag_z/c/n            datapath condition flags (BR)
//   mem_rd, mem_wr        memory request (address = src bus, data = dst bus)
//   ir                    instruction register (register-file in, data_sel=0)
//   data_sel              register-file in mux: 0 ir, 1 mem_rdata, 2 src bus
//   src_sel, dst_sel      register-file port selects
//   in_en, up_en, lo_en   full / high-byte / low-byte write of dst_sel
//   pc_inc, sp_inc, sp_dec, jp_en, br_en   PC/SP update strobes
//   halted                core stopped by HLT
module control_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ready,
  input  logic        flag_z,
  input  logic        flag_c,
  input  logic        flag_n,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [15:0] ir,
  output logic [1:0]  data_sel,
  output logic [2:0]  src_sel,
  output logic [2:0]  dst_sel,
  output logic        in_en,
  output logic        up_en,
  output logic        lo_en,
  output logic        pc_inc,
  output logic        sp_inc,
  output logic        sp_dec,
  output logic        jp_en,
  output logic        br_en,
  output logic        halted
);

  typedef enum logic [1:0] {FETCH, EXEC, MEM, HALT} state_t;

  localparam logic [3:0] OP_LDU  = 4'h1;
  localparam logic [3:0] OP_LDL  = 4'h2;
  localparam logic [3:0] OP_MOV  = 4'h3;
  localparam logic [3:0] OP_LD   = 4'h4;
  localparam logic [3:0] OP_ST   = 4'h5;
  localparam logic [3:0] OP_PUSH = 4'h6;
  localparam logic [3:0] OP_POP  = 4'h7;
  localparam logic [3:0] OP_JMP  = 4'h8;
  localparam logic [3:0] OP_BR   = 4'h9;
  localparam logic [3:0] OP_HLT  = 4'hF;

  localparam logic [1:0] DS_IR  = 2'd0;
  localparam logic [1:0] DS_MEM = 2'd1;
  localparam logic [1:0] DS_SRC = 2'd2;

  localparam logic [2:0] R_PC = 3'd0;
  localparam logic [2:0] R_SP = 3'd1;

  state_t     state, state_nx;
  logic       ir_ld;
  logic       br_cond;
  logic [3:0] op;
  logic [2:0] rd, rs;

  assign op = ir[15:12];
  assign rd = ir[11:9];
  assign rs = ir[8:6];

  always_comb begin
    case (ir[11:8])
      4'd0:    br_cond = 1'b1;
      4'd1:    br_cond = flag_z;
      4'd2:    br_cond = !flag_z;
      4'd3:    br_cond = flag_c;
      4'd4:    br_cond = !flag_c;
      4'd5:    br_cond = flag_n;
      4'd6:    br_cond = !flag_n;
      default: br_cond = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FETCH;
      ir    <= 16'h0000;
    end else begin
      state <= state_nx;
      if (ir_ld) ir <= mem_rdata;
    end
  end

  // Outputs are combinational from state/ir; while rst is high they are
  // forced idle so a request in progress is dropped in the same cycle.
  always_comb begin
    state_nx = state;
    ir_ld    = 1'b0;
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    data_sel = DS_IR;
    src_sel  = R_PC;
    dst_sel  = R_PC;
    in_en    = 1'b0;
    up_en    = 1'b0;
    lo_en    = 1'b0;
    pc_inc   = 1'b0;
    sp_inc   = 1'b0;
    sp_dec   = 1'b0;
    jp_en    = 1'b0;
    br_en    = 1'b0;
    halted   = 1'b0;
    if (!rst) begin
      case (state)
        FETCH: begin
          mem_rd = 1'b1;
          if (mem_ready) begin
            ir_ld    = 1'b1;
            pc_inc   = 1'b1;
            state_nx = EXEC;
          end
        end
        EXEC: begin
          state_nx = FETCH;
          case (op)
            OP_LDU: begin
              dst_sel = rd;
              up_en   = 1'b1;
            end
            OP_LDL: begin
              dst_sel = rd;
              lo_en   = 1'b1;
            end
            OP_MOV: begin
              src_sel  = rs;
              dst_sel  = rd;
              data_sel = DS_SRC;
              in_en    = 1'b1;
            end
            OP_LD: begin
              src_sel  = rs;
              dst_sel  = rd;
              data_sel = DS_MEM;
              mem_rd   = 1'b1;
              in_en    = mem_ready;
              if (!mem_ready) state_nx = EXEC;
            end
            OP_ST: begin
              src_sel = rs;
              dst_sel = rd;
              mem_wr  = 1'b1;
              if (!mem_ready) state_nx = EXEC;
            end
            OP_PUSH: begin
              sp_dec   = 1'b1;
              state_nx = MEM;
            end
            OP_POP: begin
              src_sel  = R_SP;
              dst_sel  = rd;
              data_sel = DS_MEM;
              mem_rd   = 1'b1;
              in_en    = mem_ready;
              state_nx = mem_ready ? MEM : EXEC;
            end
            OP_JMP:  jp_en = 1'b1;
            OP_BR:   br_en = br_cond;
            OP_HLT:  state_nx = HALT;
            default: ;
          endcase
        end
        MEM: begin
          state_nx = FETCH;
          if (op == OP_PUSH) begin
            src_sel = R_SP;
            dst_sel = rd;
            mem_wr  = 1'b1;
            if (!mem_ready) state_nx = MEM;
          end else if (op == OP_POP) begin
            sp_inc = 1'b1;
          end
        end
        HALT: halted = 1'b1;
        default: state_nx = FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Directed-vector bench for control_unit. Each vector drives inputs for one
// clock cycle and checks all outputs (plus ir) in the middle of that cycle.
module tb_control_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] mem_rdata = 16'h0;
  logic        mem_ready = 1'b0;
  logic        flag_z = 1'b0, flag_c = 1'b0, flag_n = 1'b0;
  logic        mem_rd, mem_wr;
  logic [15:0] ir;
  logic [1:0]  data_sel;
  logic [2:0]  src_sel, dst_sel;
  logic        in_en, up_en, lo_en, pc_inc, sp_inc, sp_dec, jp_en, br_en, halted;

  control_unit dut (
    .clk(clk), .rst(rst), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .flag_z(flag_z), .flag_c(flag_c), .flag_n(flag_n),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .ir(ir), .data_sel(data_sel),
    .src_sel(src_sel), .dst_sel(dst_sel), .in_en(in_en), .up_en(up_en),
    .lo_en(lo_en), .pc_inc(pc_inc), .sp_inc(sp_inc), .sp_dec(sp_dec),
    .jp_en(jp_en), .br_en(br_en), .halted(halted)
  );

  always #5 clk = ~clk;

  // strobe mask bits: {in,up,lo,pc_inc,sp_inc,sp_dec,jp,br,halted}
  localparam logic [8:0] IN  = 9'h100, UP  = 9'h080, LO = 9'h040,
                         PC  = 9'h020, SPI = 9'h010, SPD = 9'h008,
                         JP  = 9'h004, BR  = 9'h002, HLT = 9'h001, NONE = 9'h000;

  typedef struct {
    logic        rst;
    logic [15:0] rdata;
    logic        ready;
    logic [2:0]  znc;
    logic        rd;
    logic        wr;
    logic [1:0]  ds;
    logic [2:0]  src;
    logic [2:0]  dst;
    logic [8:0]  stb;
    logic [15:0] ir;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic add(input logic r, input logic [15:0] rdata, input logic ready,
                     input logic [2:0] znc, input logic erd, input logic ewr,
                     input logic [1:0] eds, input logic [2:0] esrc,
                     input logic [2:0] edst, input logic [8:0] estb,
                     input logic [15:0] eir);
    vec_t v;
    v.rst = r; v.rdata = rdata; v.ready = ready; v.znc = znc;
    v.rd = erd; v.wr = ewr; v.ds = eds; v.src = esrc; v.dst = edst;
    v.stb = estb; v.ir = eir;
    vecs.push_back(v);
  endtask

  function automatic logic [34:0] pack_exp(input logic erd, input logic ewr,
      input logic [1:0] eds, input logic [2:0] esrc, input logic [2:0] edst,
      input logic [8:0] estb, input logic [15:0] eir);
    return {erd, ewr, eds, esrc, edst, estb, eir};
  endfunction

  function automatic logic [34:0] pack_dut();
    return {mem_rd, mem_wr, data_sel, src_sel, dst_sel,
            in_en, up_en, lo_en, pc_inc, sp_inc, sp_dec, jp_en, br_en, halted, ir};
  endfunction

  task automatic check(input string name, input logic [34:0] exp_v);
    logic [34:0] got;
    got = pack_dut();
    n_vec++;
    if (got !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got rd/wr/ds/src/dst/stb/ir=%0b/%0b/%0d/%0d/%0d/%03h/%04h want %0b/%0b/%0d/%0d/%0d/%03h/%04h",
               name, got[34], got[33], got[32:31], got[30:28], got[27:25], got[24:16], got[15:0],
               exp_v[34], exp_v[33], exp_v[32:31], exp_v[30:28], exp_v[27:25], exp_v[24:16], exp_v[15:0]);
    end
  endtask

  initial begin
    // reset
    add(1, 16'h0000, 0, 3'b000, 0,0,0,0,0, NONE, 16'h0000);
    // LDU r2,0x12; LDL r2,0x34; HLT (one fetch wait on HLT)
    add(0, 16'h1412, 1, 3'b000, 1,0,0,0,0, PC,   16'h0000);
    add(0, 16'h0000, 1, 3'b000, 0,0,0,0,2, UP,   16'h1412);
    add(0, 16'h2434, 1, 3'b000, 1,0,0,0,0, PC,   16'h1412);
    add(0, 16'h0000, 1, 3'b000, 0,0,0,0,2, LO,   16'h2434);
    add(0, 16'hF000, 0, 3'b000, 1,0,0,0,0, NONE, 16'h2434);
    add(0, 16'hF000, 1, 3'b000, 1,0,0,0,0, PC,   16'h2434);
    add(0, 16'h0000, 1, 3'b000, 0,0,0,0,0, NONE, 16'hF000);
    add(0, 16'h0000, 1, 3'b111, 0,0,0,0,0, HLT,  16'hF000);
    add(0, 16'h0000, 1, 3'b111, 0,0,0,0,0, HLT,  16'hF000);
    add(1, 16'h0000, 0, 3'b000, 0,0,0,0,0, NONE, 16'h0000);
    // LD r3,[r4] with 3 wait cycles
    add(0, 16'h4700, 1, 3'b000, 1,0,0,0,0, PC,   16'h0000);
    add(0, 16'h0000, 0, 3'b000, 1,0,1,4,3, NONE, 16'h4700);
    add(0, 16'h0000, 0, 3'b000, 1,0,1,4,3, NONE, 16'h4700);
    add(0, 16'h0000, 0, 3'b000, 1,0,1,4,3, NONE, 16'h4700);
    add(0, 16'hABCD, 1, 3'b000, 1,0,1,4,3, IN,   16'h4700);
    // PUSH r5; POP r6
    add(0, 16'h6A00, 1, 3'b000, 1,0,0,0,0, PC,   16'h4700);
    add(0, 16'h0000, 1, 3'b000, 0,0,0,0,0, SPD,  16'h6A00);
    add(0, 16'h0000, 1, 3'b000, 0,1,0,1,5, NONE, 16'h6A00);
    add(0, 16'h7C00, 1, 3'b000, 1,0,0,0,0, PC,   16'h6A00);
    add(0, 16'hBEEF, 1, 3'b000, 1,0,1,1,6, IN,   16'h7C00);
    add(0, 16'h0000, 1, 3'b000, 0,0,0,0,0, SPI,  16'h7C00);
    // BR variants: Z taken, Z not taken, !Z taken, C taken, !N not, cond 7 never
    add(0, 16'h9185, 1, 3'b000, 1,0,0,0,0, PC,   16'h7C00);
    add(0, 16'h0000, 1, 3'b100, 0,0,0,0,0, BR,   16'h9185);
    add(0, 16'h9185, 1, 3'b000, 1,0,0,0,0, PC,   16'h9185);
    add(0, 16'h0000, 1, 3'b000, 0,0,0,0,0, NONE, 16'h9185);
    add(0, 16'h9205, 1, 3'b000, 1,0,0,0,0, PC,   16'h9185);
    add(0, 16'h0000, 1, 3'b000, 0,0,0,0,0, BR,   16'h9205);
    add(0, 16'h9305, 1, 3'b000, 1,0,0,0,0, PC,   16'h9205);
    add(0, 16'h0000, 1, 3'b010, 0,0,0,0,0, BR,   16'h9305);
    add(0, 16'h9605, 1, 3'b000, 1,0,0,0,0, PC,   16'h9305);
    add(0, 16'h0000, 1, 3'b001, 0,0,0,0,0, NONE, 16'h9605);
    add(0, 16'h9705, 1, 3'b000, 1,0,0,0,0, PC,   16'h9605);
    add(0, 16'h0000, 1, 3'b111, 0,0,0,0,0, NONE, 16'h9705);
    // JMP +0x7FF
    add(0, 16'h87FF, 1, 3'b000, 1,0,0,0,0, PC,   16'h9705);
    add(0, 16'h0000, 1, 3'b000, 0,0,0,0,0, JP,   16'h87FF);
    // MOV r0,r7 (absolute jump via in_en to r0)
    add(0, 16'h31C0, 1, 3'b000, 1,0,0,0,0, PC,   16'h87FF);
    add(0, 16'h0000, 1, 3'b000, 0,0,2,7,0, IN,   16'h31C0);
    // ST r2,[r3] with one wait
    add(0, 16'h54C0, 1, 3'b000, 1,0,0,0,0, PC,   16'h31C0);
    add(0, 16'h0000, 0, 3'b000, 0,1,0,3,2, NONE, 16'h54C0);
    add(0, 16'h0000, 1, 3'b000, 0,1,0,3,2, NONE, 16'h54C0);
    // opcode A executes as NOP; NOP; fetch stall
    add(0, 16'hA123, 1, 3'b000, 1,0,0,0,0, PC,   16'h54C0);
    add(0, 16'h0000, 1, 3'b000, 0,0,0,0,0, NONE, 16'hA123);
    add(0, 16'h0000, 1, 3'b000, 1,0,0,0,0, PC,   16'hA123);
    add(0, 16'h0000, 1, 3'b000, 0,0,0,0,0, NONE, 16'h0000);
    add(0, 16'h0000, 0, 3'b000, 1,0,0,0,0, NONE, 16'h0000);
    // PUSH r1 with one wait on the store
    add(0, 16'h6200, 1, 3'b000, 1,0,0,0,0, PC,   16'h0000);
    add(0, 16'h0000, 1, 3'b000, 0,0,0,0,0, SPD,  16'h6200);
    add(0, 16'h0000, 0, 3'b000, 0,1,0,1,1, NONE, 16'h6200);
    add(0, 16'h0000, 1, 3'b000, 0,1,0,1,1, NONE, 16'h6200);
    add(0, 16'h0000, 0, 3'b000, 1,0,0,0,0, NONE, 16'h6200);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst       = vecs[i].rst;
      mem_rdata = vecs[i].rdata;
      mem_ready = vecs[i].ready;
      {flag_z, flag_c, flag_n} = vecs[i].znc;
      #1;
      check($sformatf("vec%0d", i),
            pack_exp(vecs[i].rd, vecs[i].wr, vecs[i].ds, vecs[i].src,
                     vecs[i].dst, vecs[i].stb, vecs[i].ir));
    end

    // Reset asserted mid-cycle during a stalled LD r3,[r4]
    {flag_z, flag_c, flag_n} = 3'b000;
    @(negedge clk); rst = 1'b1; mem_ready = 1'b0;
    @(negedge clk); rst = 1'b0; mem_rdata = 16'h4700; mem_ready = 1'b1;
    #1 check("rstld_fetch", pack_exp(1,0,0,0,0, PC, 16'h0000));
    @(negedge clk); mem_ready = 1'b0; mem_rdata = 16'h5555;
    #1 check("rstld_stall1", pack_exp(1,0,1,4,3, NONE, 16'h4700));
    @(negedge clk);
    #1 check("rstld_stall2", pack_exp(1,0,1,4,3, NONE, 16'h4700));
    #1 rst = 1'b1;
    #1 check("rstld_async", pack_exp(0,0,0,0,0, NONE, 16'h0000));
    // mem_ready arriving while reset is held must not produce a write
    mem_ready = 1'b1;
    #1 check("rstld_hold", pack_exp(0,0,0,0,0, NONE, 16'h0000));
    @(negedge clk); rst = 1'b0; mem_ready = 1'b0;
    #1 check("rstld_refetch", pack_exp(1,0,0,0,0, NONE, 16'h0000));
    @(negedge clk); mem_ready = 1'b1; mem_rdata = 16'h0000;
    #1 check("rstld_refetch_rdy", pack_exp(1,0,0,0,0, PC, 16'h0000));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/control_unit.md
# control_unit

Multi-cycle fetch/execute sequencer for the tiny16 core. It owns the instruction register and drives every select and strobe of the 8×16 general register file (r0 = PC, r1 = SP). It also drives the single-port memory request handshake, so the register file, memory and condition flags together execute one instruction at a time.

## Interface
Parameters: none.

Ports:
- clk  in  1  clock; all state advances on rising edge.
- rst  in  1  asynchronous, active-high reset.
- mem_rdata  in  16  memory read data, valid when mem_ready=1.
- mem_ready  in  1  memory completes current mem_rd/mem_wr this cycle.
- flag_z, flag_c, flag_n  in  1 each  condition flags from the datapath.
- mem_rd  out  1  read request; address is the register-file src bus.
- mem_wr  out  1  write request; address is the src bus, data is the dst bus.
- ir  out  16  instruction register; drives register-file `in` when data_sel=0.
- data_sel  out  2  register-file `in` mux: 0 = ir, 1 = mem_rdata, 2 = src bus.
- src_sel, dst_sel  out  3 each  register-file port selects.
- in_en, up_en, lo_en  out  1 each  full / high-byte / low-byte write of dst_sel.
- pc_inc, sp_inc, sp_dec, jp_en, br_en  out  1 each  PC/SP update strobes.
- halted  out  1  core stopped by HLT.

## Operation
- Encoding: op = ir[15:12], rd = ir[11:9], rs = ir[8:6].
- Opcodes:
  - 0 NOP.
  - 1 LDU: rd[15:8] ← ir[7:0].
  - 2 LDL: rd[7:0] ← ir[7:0].
  - 3 MOV: rd ← rs.
  - 4 LD: rd ← mem[rs].
  - 5 ST: mem[rs] ← rd.
  - 6 PUSH rd: SP−1, then mem[SP] ← rd.
  - 7 POP rd: rd ← mem[SP], then SP+1.
  - 8 JMP: PC ± ir[10:0], direction ir[11].
  - 9 BR: cond = ir[11:8], PC ± ir[6:0], direction ir[7].
  - F HLT.
  - A–E are executed as NOP.
- BR conditions: 0 always, 1 Z, 2 !Z, 3 C, 4 !C, 5 N, 6 !N; 7–F never taken.
- States: FETCH, EXEC, MEM, HALT.
- FETCH:
  - src_sel=0, mem_rd=1; hold until mem_ready.
  - In the ready cycle: ir ← mem_rdata, pc_inc=1 → EXEC.
- EXEC (all strobes decode from ir):
  - NOP / A–E: no strobes → FETCH.
  - LDU / LDL: dst_sel=rd, data_sel=0, up_en or lo_en → FETCH.
  - MOV: src_sel=rs, dst_sel=rd, data_sel=2, in_en → FETCH.
  - LD: src_sel=rs, dst_sel=rd, data_sel=1, mem_rd held; in_en only in the ready cycle → FETCH.
  - ST: src_sel=rs, dst_sel=rd, mem_wr held until ready → FETCH.
  - PUSH: sp_dec → MEM.
  - POP: src_sel=1, dst_sel=rd, data_sel=1, mem_rd held; in_en in the ready cycle → MEM.
  - JMP: data_sel=0, jp_en → FETCH.
  - BR: br_en=1 iff condition true, data_sel=0 → FETCH.
  - HLT → HALT.
- MEM:
  - PUSH: src_sel=1, dst_sel=rd, mem_wr held until ready → FETCH.
  - POP: sp_inc → FETCH.
- HALT: all strobes 0, halted=1; exit only by rst.
- Jump/branch offsets are relative to the already-incremented PC; arithmetic is 16-bit and wraps mod 2^16.

## Timing
- Reset values:
  - state = FETCH, ir = 0x0000, halted = 0.
  - All strobes and mem_rd/mem_wr = 0.
  - src_sel = dst_sel = 0, data_sel = 0.
- Request assertion: mem_rd/mem_wr are asserted combinationally from state and ir. The address and data selects stay constant while a request is held.
- mem_ready is ignored when no request is asserted.
- Cycle counts with zero-wait memory:
  - NOP/LDU/LDL/MOV/JMP/BR/ST/LD: 2 cycles.
  - PUSH/POP: 3 cycles.
  - Each wait cycle adds 1 cycle.
- Strobe exclusivity: at most one of in_en/up_en/lo_en per cycle. At most one of pc_inc/jp_en/br_en/in_en-to-r0 per cycle. At most one SP strobe per cycle.
- Writes to r0 (MOV/LD with rd=0) act as absolute jumps.
- POP with rd=1: SP = loaded value + 1. PUSH with rd=1 stores the decremented SP.
- Async reset mid-request drops mem_rd/mem_wr immediately. The next fetch starts from PC reset state.

## Test plan
- Reset, zero-wait memory, program LDU r2,0x12; LDL r2,0x34; HLT → r2 = 0x1234, PC = 3, halted=1 from cycle 6, no further mem_rd.
- LD r3,[r4] with mem_ready delayed 3 cycles → mem_rd held 4 cycles with src_sel=4, single in_en pulse on the ready cycle, r3 = mem_rdata.
- SP = 0x00FF, r5 = 0xBEEF, PUSH r5; POP r6 → write to 0x00FE data 0xBEEF, r6 = 0xBEEF, SP back to 0x00FF, 6 cycles total.
- At PC = 0x0010: BR cond=1 offset back 5 (ir = 0x9185) with flag_z=1 → PC = 0x000C. With flag_z=0 → br_en never asserted, PC = 0x0011.
- JMP +0x7FF at PC = 0xF900 (after fetch 0xF901) → PC = 0x0100 (wrap).
- Assert rst during a stalled LD → all outputs at reset values the same cycle, the destination register is not written, fetch restarts at PC 0.
